// File: rtl/seg7_scan_8dig.sv
// Eight-digit common-anode 7-segment scanner. It takes a frame-coherent snapshot
// of the decoder latch outputs and inserts a blank gap at the start of each digit slot.
module seg7_scan_8dig #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] data_in_0,
    input  logic [3:0] data_in_1,
    input  logic [3:0] data_in_2,
    input  logic [3:0] data_in_3,
    input  logic [3:0] data_in_4,
    input  logic [3:0] data_in_5,
    input  logic [3:0] data_in_6,
    input  logic [3:0] data_in_7,
    input  logic [7:0] dp_in,
    input  logic [7:0] dig_en,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp_n,
    output logic       frame_tick
);

    localparam int            CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [3:0]    snap_data [8];
    logic [7:0]    snap_dp;
    logic [7:0]    snap_en;

    logic          slot_end;
    logic          frame_end;
    logic          in_gap;
    logic [3:0]    cur_data;
    logic          cur_en;
    logic          cur_dp;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == 3'd7);
    assign cur_data  = snap_data[idx];
    assign cur_en    = snap_en[idx];
    assign cur_dp    = snap_dp[idx];

    // With no gap the comparison would be constant-false, so it is elided entirely.
    generate
        if (BLANK_CYC == 0) begin : g_no_gap
            assign in_gap = 1'b0;
        end else begin : g_gap
            assign in_gap = (cnt < CW'(BLANK_CYC));
        end
    endgenerate

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (slot_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // idx wraps 7 -> 0 naturally through the 3-bit width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= 3'd0;
        end else if (slot_end) begin
            idx <= idx + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                snap_data[i] <= 4'h0;
            end
            snap_dp    <= 8'h00;
            snap_en    <= 8'h00;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (frame_end) begin
                snap_data[0] <= data_in_0;
                snap_data[1] <= data_in_1;
                snap_data[2] <= data_in_2;
                snap_data[3] <= data_in_3;
                snap_data[4] <= data_in_4;
                snap_data[5] <= data_in_5;
                snap_data[6] <= data_in_6;
                snap_data[7] <= data_in_7;
                snap_dp      <= dp_in;
                snap_en      <= dig_en;
            end
        end
    end

    // Registered drivers: at most one anode can ever be low since an is a single decoded shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an   <= 8'hFF;
            seg  <= 7'h7F;
            dp_n <= 1'b1;
        end else if (in_gap || !cur_en) begin
            an   <= 8'hFF;
            seg  <= 7'h7F;
            dp_n <= 1'b1;
        end else begin
            an   <= ~(8'b1 << idx);
            seg  <= glyph(cur_data);
            dp_n <= ~cur_dp;
        end
    end

endmodule

// File: tb/tb_seg7_scan_8dig.sv
// Directed self-checking bench for seg7_scan_8dig with SCAN_DIV=4, BLANK_CYC=1.
// Each frame spans 32 cycles; outputs are sampled 1 time unit after each rising edge.
module tb_seg7_scan_8dig;

    logic       clk;
    logic       rst;
    logic [3:0] data_in_0, data_in_1, data_in_2, data_in_3;
    logic [3:0] data_in_4, data_in_5, data_in_6, data_in_7;
    logic [7:0] dp_in;
    logic [7:0] dig_en;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    seg7_scan_8dig #(.SCAN_DIV(4), .BLANK_CYC(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in_0  (data_in_0),
        .data_in_1  (data_in_1),
        .data_in_2  (data_in_2),
        .data_in_3  (data_in_3),
        .data_in_4  (data_in_4),
        .data_in_5  (data_in_5),
        .data_in_6  (data_in_6),
        .data_in_7  (data_in_7),
        .dp_in      (dp_in),
        .dig_en     (dig_en),
        .an         (an),
        .seg        (seg),
        .dp_n       (dp_n),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and verify at most one anode is active.
    task automatic tick();
        @(posedge clk);
        #1;
        check_output("onehot_an", {31'd0, ($countones(~an) <= 1)}, 32'd1);
    endtask

    task automatic apply_stimulus(input logic [31:0] vals, input logic [7:0] dp, input logic [7:0] en);
        data_in_0 = vals[3:0];
        data_in_1 = vals[7:4];
        data_in_2 = vals[11:8];
        data_in_3 = vals[15:12];
        data_in_4 = vals[19:16];
        data_in_5 = vals[23:20];
        data_in_6 = vals[27:24];
        data_in_7 = vals[31:28];
        dp_in     = dp;
        dig_en    = en;
    endtask

    // Walk slots first..last of a displayed frame; slot cycle 0 is the blank gap.
    task automatic check_slots(input string tag, input int first, input int last,
                               input logic [31:0] vals, input logic [7:0] dp, input logic [7:0] en);
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        for (int s = first; s <= last; s++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                if (c == 0 || !en[s]) begin
                    exp_an  = 8'hFF;
                    exp_seg = 7'h7F;
                    exp_dp  = 1'b1;
                end else begin
                    exp_an  = ~(8'd1 << s);
                    exp_seg = glyph(vals[s*4 +: 4]);
                    exp_dp  = ~dp[s];
                end
                check_output({tag, "_an"}, {24'd0, an}, {24'd0, exp_an});
                check_output({tag, "_seg"}, {25'd0, seg}, {25'd0, exp_seg});
                check_output({tag, "_dp_n"}, {31'd0, dp_n}, {31'd0, exp_dp});
                check_output({tag, "_tick"}, {31'd0, frame_tick}, {31'd0, (s == 7 && c == 3)});
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        apply_stimulus(32'h76543210, 8'h00, 8'hFF);
        repeat (3) tick();
        check_output("reset_an", {24'd0, an}, 32'h0000_00FF);
        check_output("reset_seg", {25'd0, seg}, 32'h0000_007F);
        check_output("reset_dp_n", {31'd0, dp_n}, 32'd1);
        check_output("reset_tick", {31'd0, frame_tick}, 32'd0);
        rst = 1'b0;

        $display("[TB] blank first frame, then digits 0..7");
        check_slots("f0_blank", 0, 7, 32'h76543210, 8'h00, 8'h00);
        apply_stimulus(32'h7654A210, 8'h08, 8'hFF);
        check_slots("f1_digits", 0, 7, 32'h76543210, 8'h00, 8'hFF);

        $display("[TB] digit 3 = A with dp, then mid-frame change of digit 5");
        check_slots("f2_first", 0, 3, 32'h7654A210, 8'h08, 8'hFF);
        apply_stimulus(32'h76E4A210, 8'h08, 8'hFF);
        check_slots("f2_second", 4, 7, 32'h7654A210, 8'h08, 8'hFF);
        apply_stimulus(32'h76E4A210, 8'h08, 8'h0F);
        check_slots("f3_e", 0, 7, 32'h76E4A210, 8'h08, 8'hFF);

        $display("[TB] upper digits disabled");
        apply_stimulus(32'h76E4A210, 8'h08, 8'hFF);
        check_slots("f4_en0f", 0, 7, 32'h76E4A210, 8'h08, 8'h0F);

        $display("[TB] asynchronous reset in digit 6 slot");
        check_slots("f5_pre", 0, 5, 32'h76E4A210, 8'h08, 8'hFF);
        tick();
        check_output("slot6_gap_an", {24'd0, an}, 32'h0000_00FF);
        tick();
        check_output("slot6_an", {24'd0, an}, 32'h0000_00BF);
        check_output("slot6_seg", {25'd0, seg}, {25'd0, glyph(4'h6)});
        #2;
        rst = 1'b1;
        #1;
        check_output("async_an", {24'd0, an}, 32'h0000_00FF);
        check_output("async_seg", {25'd0, seg}, 32'h0000_007F);
        check_output("async_dp_n", {31'd0, dp_n}, 32'd1);
        data_in_0 = 4'h0;
        repeat (2) tick();
        rst = 1'b0;
        check_slots("post_reset_blank", 0, 7, 32'h76E4A210, 8'h08, 8'h00);

        $display("[TB] glyph sweep on digit 0");
        for (int v = 0; v < 16; v++) begin
            data_in_0 = 4'(v + 1);
            check_slots("sweep", 0, 7, {28'h76E4A21, 4'(v)}, 8'h08, 8'hFF);
        end

        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_8dig.md
Name: seg7_scan_8dig

Overview:
- Downstream consumer of the 8-way 3-8 decoder/latch bank.
- Takes the eight 4-bit latched digit outputs and drives one common-anode 8-digit 7-segment display by time-multiplexed scanning.
- Each value is displayed as a hex glyph. A frame-coherent snapshot prevents tearing, and a programmable blank gap between digits suppresses ghosting.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot (must be ≥2).
- BLANK_CYC, 500, cycles at the start of each slot with all anodes off (must be < SCAN_DIV, may be 0).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- data_in_0 .. data_in_7  input  4 each  digit values from decoder latch outputs 0..7.
- dp_in  input  8  decimal point request per digit, bit i = digit i, 1 = lit.
- dig_en  input  8  per-digit display enable, 1 = shown, 0 = blanked.
- an  output  8  anode select, active-low, bit i = digit i.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  output  1  decimal point, active-low.
- frame_tick  output  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- Reset (async assert, sync to clk on release): cnt=0, idx=0, snap_data*=0, snap_dp=0, snap_en=0, an=8'hFF, seg=7'h7F, dp_n=1, frame_tick=0.
- Prescaler cnt runs 0..SCAN_DIV-1 and wraps to 0. slot_end = (cnt==SCAN_DIV-1).
- Digit index idx advances on slot_end: 0→1→…→7→0.
- Snapshot: on the edge where slot_end && idx==7:
  - all data_in_i, dp_in and dig_en are captured into snap registers;
  - idx becomes 0;
  - frame_tick is 1 in the following cycle only.
- Input changes between snapshots have no visible effect.
- Output latency: an/seg/dp_n are registered. Their value in cycle t+1 is a function of cnt, idx and snap in cycle t.
- Blanking: if cnt < BLANK_CYC, or snap_en[idx]==0, then an=8'hFF, seg=7'h7F, dp_n=1.
- Otherwise:
  - an = ~(8'b1 << idx);
  - seg = glyph(snap_data[idx]);
  - dp_n = ~snap_dp[idx].
- Exactly zero or one anode is low in any cycle.
- Glyph table (active-low hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Full frame = 8*SCAN_DIV cycles. frame_tick period = 8*SCAN_DIV cycles.
- First frame after reset is fully blank (snap_en=0). The first snapshot occurs on the edge 8*SCAN_DIV cycles after reset release, counting the first edge as 1.
- Reset mid-slot: outputs go to the blank reset values immediately (asynchronously), without waiting for clk. Scanning restarts from idx=0, cnt=0 and a fresh blank frame.
- Simultaneous input change and snapshot edge: the value present at that edge is captured.
- BLANK_CYC=0: no gap; the anode switches directly between digits on the registered edge.

Test Plan:
(Use SCAN_DIV=4, BLANK_CYC=1.)
1. Reset, dig_en=FF, data_in_i=i → first 32 cycles an=FF, seg=7F. frame_tick pulses once, then digit 0 slot shows:
   - 1 cycle blank;
   - then 3 cycles of an=FE, seg=40;
   - then digit 1: an=FD, seg=79;
   - …
   - then digit 7: an=7F, seg=78.
2. data_in_3=A, dp_in=8'h08 → after the next frame_tick, the digit 3 slot shows an=F7, seg=08, dp_n=0. All other slots keep dp_n=1.
3. Change data_in_5 from 5 to E in the middle of a frame → the current frame still shows 12 on digit 5. The next frame shows 06.
4. dig_en=8'h0F → slots 4..7 show an=FF, seg=7F, while cnt/idx still advance. The frame_tick period stays at 32 cycles.
5. Assert rst during the digit 6 slot → an=FF immediately, before the next clk edge. After release, there are 32 blank cycles before the first frame_tick.
6. Sweep data 0..F on digit 0 → the seg sequence matches the glyph table exactly. At every cycle, popcount(~an) ≤ 1.
